slope_event_detector: RTL and testbench

Consumes the signed per-sample slope produced by the derivative stage and turns it into debounced, hysteresis-qualified rising/falling slope events. A small FSM qualifies each event, tracks peak slope magnitude, and keeps a saturating event count. It sits directly downstream of the derivative stage, on the same clock and clock-enable, and feeds the control/telemetry logic.

---
 rtl/slope_evt_pkg.sv | 18 +
 rtl/slope_abs_sat.sv | 23 ++
 rtl/slope_event_detector.sv | 134 +++++++++++++
 tb/tb_slope_event_detector.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/slope_evt_pkg.sv
// Shared definitions for the slope event detector: FSM encoding and
// the magnitude saturation limit helper.
package slope_evt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RISE_PEND = 3'd1,
    ST_RISING    = 3'd2,
    ST_FALL_PEND = 3'd3,
    ST_FALLING   = 3'd4
  } state_t;

  // Largest representable positive magnitude for a two's complement width.
  function automatic int unsigned sat_mag_limit(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/slope_abs_sat.sv
// Signed sample to unsigned magnitude; the most negative code saturates
// to the largest positive value so the result always fits in WIDTH-1 bits.
module slope_abs_sat
  import slope_evt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] din,
  output logic        [WIDTH-1:0] mag
);

  localparam logic [WIDTH-1:0] MAX_MAG  = WIDTH'(sat_mag_limit(WIDTH));
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    mag = $unsigned(din);
    if (din[WIDTH-1]) begin
      if ($unsigned(din) == MOST_NEG) mag = MAX_MAG;
      else                            mag = $unsigned(-din);
    end
  end

endmodule

// File: rtl/slope_event_detector.sv
// Debounced, hysteresis-qualified rising/falling slope event detector with
// peak magnitude capture and a saturating event counter.
module slope_event_detector
  import slope_evt_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int THRESH_HI = 8,
  parameter int THRESH_LO = 4,
  parameter int MIN_RUN   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enb,
  input  logic signed [WIDTH-1:0] In1,
  input  logic                    clr_count,
  output logic                    rise_evt,
  output logic                    fall_evt,
  output logic [2:0]              state_o,
  output logic [WIDTH-1:0]        peak,
  output logic [CNT_W-1:0]        evt_count
);

  localparam int RUN_W = $clog2(MIN_RUN + 1);

  localparam logic signed [WIDTH-1:0] TH_HI  = WIDTH'(THRESH_HI);
  localparam logic signed [WIDTH-1:0] TH_LO  = WIDTH'(THRESH_LO);
  localparam logic signed [WIDTH-1:0] NTH_HI = -TH_HI;
  localparam logic signed [WIDTH-1:0] NTH_LO = -TH_LO;

  state_t            state, state_n;
  logic [RUN_W-1:0]  run, run_n;
  logic [WIDTH-1:0]  trk, trk_n;
  logic [WIDTH-1:0]  mag;
  logic              pos, neg;
  logic              run_done;
  logic              rise_n, fall_n, pub;
  logic              same_phase;

  slope_abs_sat #(.WIDTH(WIDTH)) u_abs (
    .din (In1),
    .mag (mag)
  );

  assign pos      = (In1 >= TH_HI);
  assign neg      = (In1 <= NTH_HI);
  assign run_done = ((int'(run) + 1) >= MIN_RUN);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; every transition requires an accepted sample (enb=1)
  always_comb begin
    state_n = state;
    if (enb) begin
      case (state)
        ST_IDLE: begin
          if (pos)      state_n = (MIN_RUN == 1) ? ST_RISING  : ST_RISE_PEND;
          else if (neg) state_n = (MIN_RUN == 1) ? ST_FALLING : ST_FALL_PEND;
        end
        ST_RISE_PEND: begin
          if (pos) state_n = run_done ? ST_RISING : ST_RISE_PEND;
          else     state_n = ST_IDLE;
        end
        ST_FALL_PEND: begin
          if (neg) state_n = run_done ? ST_FALLING : ST_FALL_PEND;
          else     state_n = ST_IDLE;
        end
        ST_RISING: begin
          if (neg)               state_n = (MIN_RUN == 1) ? ST_FALLING : ST_FALL_PEND;
          else if (In1 < TH_LO)  state_n = ST_IDLE;
        end
        ST_FALLING: begin
          if (pos)               state_n = (MIN_RUN == 1) ? ST_RISING : ST_RISE_PEND;
          else if (In1 > NTH_LO) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Output/datapath decode: an event fires exactly when an active state is
  // entered, and the tracked max is published whenever an active state is left.
  always_comb begin
    rise_n     = enb && (state_n == ST_RISING)  && (state != ST_RISING);
    fall_n     = enb && (state_n == ST_FALLING) && (state != ST_FALLING);
    pub        = enb && (((state == ST_RISING)  && (state_n != ST_RISING)) ||
                         ((state == ST_FALLING) && (state_n != ST_FALLING)));
    same_phase = (((state   == ST_RISE_PEND) || (state   == ST_RISING)) &&
                  ((state_n == ST_RISE_PEND) || (state_n == ST_RISING))) ||
                 (((state   == ST_FALL_PEND) || (state   == ST_FALLING)) &&
                  ((state_n == ST_FALL_PEND) || (state_n == ST_FALLING)));

    run_n = '0;
    if (state_n == ST_RISE_PEND || state_n == ST_FALL_PEND)
      run_n = (state_n == state) ? run + RUN_W'(1) : RUN_W'(1);

    trk_n = '0;
    if (state_n != ST_IDLE) begin
      if (same_phase) trk_n = (mag > trk) ? mag : trk;
      else            trk_n = mag;
    end
  end

  // Datapath registers; pulses are written every cycle so they self-clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run       <= '0;
      trk       <= '0;
      peak      <= '0;
      evt_count <= '0;
      rise_evt  <= 1'b0;
      fall_evt  <= 1'b0;
    end else begin
      rise_evt <= rise_n;
      fall_evt <= fall_n;
      if (enb) begin
        run <= run_n;
        trk <= trk_n;
        if (pub) peak <= trk;
        if (clr_count)
          evt_count <= '0;
        else if ((rise_n || fall_n) && (evt_count != {CNT_W{1'b1}}))
          evt_count <= evt_count + CNT_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_slope_event_detector.sv
// Directed bench for slope_event_detector: default instance plus a
// MIN_RUN=1 / narrow-counter instance for the saturation corner.
module tb_slope_event_detector;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enb = 1'b0;
  logic              clr_count = 1'b0;
  logic signed [7:0] in1 = '0;
  logic signed [7:0] in2 = '0;

  logic        rise_evt, fall_evt;
  logic [2:0]  state_o;
  logic [7:0]  peak;
  logic [15:0] evt_count;

  logic        rise2, fall2;
  logic [2:0]  state2;
  logic [7:0]  peak2;
  logic [3:0]  count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slope_event_detector dut (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .In1       (in1),
    .clr_count (clr_count),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt),
    .state_o   (state_o),
    .peak      (peak),
    .evt_count (evt_count)
  );

  slope_event_detector #(.MIN_RUN(1), .CNT_W(4)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .enb       (enb),
    .In1       (in2),
    .clr_count (clr_count),
    .rise_evt  (rise2),
    .fall_evt  (fall2),
    .state_o   (state2),
    .peak      (peak2),
    .evt_count (count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int v1, input int v2, input logic e, input logic c);
    @(negedge clk);
    in1       = 8'(v1);
    in2       = 8'(v2);
    enb       = e;
    clr_count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_main(input string tag, input int st, input int r, input int f,
                             input int pk, input int cnt);
    check({tag, ".state"}, 32'(state_o), 32'(st));
    check({tag, ".rise"},  32'(rise_evt), 32'(r));
    check({tag, ".fall"},  32'(fall_evt), 32'(f));
    check({tag, ".peak"},  32'(peak), 32'(pk));
    check({tag, ".count"}, 32'(evt_count), 32'(cnt));
  endtask

  initial begin
    // Reset held with qualifying samples toggling
    sample(50, 0, 1, 0);
    expect_main("rst0", 0, 0, 0, 0, 0);
    sample(-50, 0, 1, 0);
    expect_main("rst1", 0, 0, 0, 0, 0);
    sample(50, 0, 1, 0);
    expect_main("rst2", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    sample(0, 0, 1, 0);
    expect_main("idle", 0, 0, 0, 0, 0);

    // Rising event, hysteresis band, exit
    sample(10, 0, 1, 0);
    expect_main("rise1", 1, 0, 0, 0, 0);
    sample(10, 0, 1, 0);
    expect_main("rise2", 1, 0, 0, 0, 0);
    sample(10, 0, 1, 0);
    expect_main("rise3", 2, 1, 0, 0, 1);
    sample(20, 0, 1, 0);
    expect_main("rise20", 2, 0, 0, 0, 1);
    sample(6, 0, 1, 0);
    expect_main("band", 2, 0, 0, 0, 1);
    sample(3, 0, 1, 0);
    expect_main("exit", 0, 0, 0, 20, 1);

    // Debounce: run broken before MIN_RUN
    sample(10, 0, 1, 0);
    sample(10, 0, 1, 0);
    expect_main("deb2", 1, 0, 0, 20, 1);
    sample(0, 0, 1, 0);
    expect_main("deb_abort", 0, 0, 0, 20, 1);

    // Rising at max 15, then reversal through the saturating -128
    sample(15, 0, 1, 0);
    sample(15, 0, 1, 0);
    sample(15, 0, 1, 0);
    expect_main("r15", 2, 1, 0, 20, 2);
    sample(-9, 0, 1, 0);
    expect_main("rev1", 3, 0, 0, 15, 2);
    sample(-128, 0, 1, 0);
    expect_main("rev2", 3, 0, 0, 15, 2);
    sample(-9, 0, 1, 0);
    expect_main("rev3", 4, 0, 1, 15, 3);
    sample(-5, 0, 1, 0);
    expect_main("fband", 4, 0, 0, 15, 3);
    sample(0, 0, 1, 0);
    expect_main("fexit", 0, 0, 0, 127, 3);

    // Stall mid-run, then completing sample with a same-cycle clear
    sample(10, 0, 1, 0);
    sample(10, 0, 1, 0);
    sample(10, 0, 0, 0);
    expect_main("stall1", 1, 0, 0, 127, 3);
    sample(0, 0, 0, 1);
    expect_main("stall2", 1, 0, 0, 127, 3);
    sample(10, 0, 1, 1);
    expect_main("clrwin", 2, 1, 0, 127, 0);
    sample(0, 0, 0, 0);
    expect_main("pulse_drop", 2, 0, 0, 127, 0);

    // Asynchronous abort mid-RISING
    sample(12, 0, 1, 0);
    expect_main("pre_abort", 2, 0, 0, 127, 0);
    @(negedge clk);
    in1 = 8'sd0;
    #2;
    reset = 1'b0;
    #1;
    expect_main("abort", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // MIN_RUN=1 instance: immediate events, reversal, counter saturation
    sample(0, 10, 1, 0);
    check("m1.state", 32'(state2), 32'd2);
    check("m1.rise",  32'(rise2), 32'd1);
    check("m1.count", 32'(count2), 32'd1);
    sample(0, -10, 1, 0);
    check("m1r.state", 32'(state2), 32'd4);
    check("m1r.fall",  32'(fall2), 32'd1);
    check("m1r.rise",  32'(rise2), 32'd0);
    check("m1r.peak",  32'(peak2), 32'd10);
    check("m1r.count", 32'(count2), 32'd2);
    for (int i = 0; i < 16; i++) begin
      sample(0, (i % 2 == 0) ? 10 : -10, 1, 0);
      check("sat.excl", 32'(rise2 & fall2), 32'd0);
      check("sat.one",  32'(rise2 | fall2), 32'd1);
    end
    check("sat.count", 32'(count2), 32'd15);
    sample(0, 10, 1, 1);
    check("sat.clr", 32'(count2), 32'd0);
    check("sat.main_idle", 32'(state_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
